// File: rtl/hit_detector_n_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hit_det_pkg
//  Description : Shared types, constants and width helpers for the
//                parametrised hit detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package hit_det_pkg;

    // Classification code reserved for "no dominant bin".
    localparam int SILENCE = 0;

    // Onset/hold-off state machine encoding.
    typedef enum logic [1:0] {
        ST_QUIET   = 2'd0,
        ST_HELD    = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

    // Width of a classification code: 0 (silence) plus codes 1..num_bins.
    function automatic int code_width(input int num_bins);
        return $clog2(num_bins + 1);
    endfunction

    // Width of a vote counter able to hold 0..window.
    function automatic int count_width(input int window);
        return $clog2(window + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hit_detector_n_if.sv
`default_nettype none
// ============================================================================
//  Module      : hit_detector_n_if
//  Description : Power-sample input and hit-report output bundle of the
//                hit detector. The producer/reader side uses master, the
//                detector uses slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hit_detector_n_if
    import hit_det_pkg::*;
#(
    parameter int NUM_BINS = 4,
    parameter int POWER_W  = 64,
    parameter int WINDOW   = 16
);
    localparam int RW = code_width(NUM_BINS);
    localparam int CW = count_width(WINDOW);

    logic                        advance;
    logic [NUM_BINS*POWER_W-1:0] power;
    logic [RW-1:0]               result;
    logic [RW-1:0]               overall_result;
    logic                        hit_valid;
    logic [RW-1:0]               hit_bin;
    logic [CW-1:0]               silence_votes;

    modport master (
        output advance, power,
        input  result, overall_result, hit_valid, hit_bin, silence_votes
    );

    modport slave (
        input  advance, power,
        output result, overall_result, hit_valid, hit_bin, silence_votes
    );

endinterface
`default_nettype wire

// File: rtl/hit_detector_n_vote_window.sv
`default_nettype none
// ============================================================================
//  Module      : vote_window
//  Description : Sliding window of the last WINDOW classification codes with
//                one running occurrence counter per code (silence included).
//  Revision    : 1.0 - initial release
// ============================================================================
module vote_window
    import hit_det_pkg::*;
#(
    parameter  int NUM_BINS = 4,
    parameter  int WINDOW   = 16,
    localparam int RW       = code_width(NUM_BINS),
    localparam int CW       = count_width(WINDOW)
) (
    input  wire logic                          clk,
    input  wire logic                          reset,
    input  wire logic                          shift_en,
    input  wire logic [RW-1:0]                 din,
    output logic      [NUM_BINS-1:0][CW-1:0]   counts,
    output logic      [CW-1:0]                 silence_votes
);

    // Slot 0 is the newest entry, slot WINDOW-1 the one dropped next.
    logic [WINDOW-1:0][RW-1:0]   win_q, win_d;
    // Index 0 counts silence, index c counts bin code c.
    logic [NUM_BINS:0][CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]               old_w;

    assign old_w = win_q[WINDOW-1];

    // Shift in the new code; only the entering and leaving codes' counts move,
    // and nothing moves when they are the same code.
    always_comb begin
        win_d = win_q;
        cnt_d = cnt_q;
        if (shift_en) begin
            win_d = {win_q[WINDOW-2:0], din};
            if (din != old_w) begin
                for (int c = 0; c <= NUM_BINS; c++) begin
                    if (RW'(c) == din)
                        cnt_d[c] = cnt_q[c] + CW'(1);
                    else if (RW'(c) == old_w)
                        cnt_d[c] = cnt_q[c] - CW'(1);
                end
            end
        end
    end

    // Window starts full of silence.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < WINDOW; s++)
                win_q[s] <= RW'(SILENCE);
            for (int c = 0; c <= NUM_BINS; c++)
                cnt_q[c] <= (c == SILENCE) ? CW'(WINDOW) : '0;
        end else begin
            win_q <= win_d;
            cnt_q <= cnt_d;
        end
    end

    assign counts        = cnt_q[NUM_BINS:1];
    assign silence_votes = cnt_q[0];

endmodule
`default_nettype wire

// File: rtl/hit_detector_n.sv
`default_nettype none
// ============================================================================
//  Module      : hit_detector_n
//  Description : Classifies NUM_BINS power inputs into silence or one dominant
//                bin per advance strobe, takes a windowed majority vote and
//                reports hit onsets through a hold-off state machine.
//  Revision    : 1.0 - initial release
// ============================================================================
module hit_detector_n
    import hit_det_pkg::*;
#(
    parameter int              NUM_BINS  = 4,
    parameter int              POWER_W   = 64,
    parameter int              SHIFT     = 3,
    parameter longint unsigned MIN_POWER = 0,
    parameter int              WINDOW    = 16,
    parameter int              THRESH    = 8,
    parameter int              HOLDOFF   = 4
) (
    input  wire logic       clk,
    input  wire logic       reset,
    hit_detector_n_if.slave bus
);

    localparam int                 RW    = code_width(NUM_BINS);
    localparam int                 CW    = count_width(WINDOW);
    localparam int                 HW    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [POWER_W-1:0] MIN_P = POWER_W'(MIN_POWER);

    logic [POWER_W-1:0]          pw_w [NUM_BINS];
    logic [NUM_BINS-1:0]         floor_ok_w;
    logic [RW-1:0]               cls_w;
    logic                        found_w;
    logic                        dom_w;
    logic [RW-1:0]               nov_w;
    logic [NUM_BINS-1:0][CW-1:0] counts_w;
    logic [CW-1:0]               silence_w;

    logic [RW-1:0] result_q, result_d;
    logic          adv1_q, adv2_q;
    state_e        state_q, state_d;
    logic [RW-1:0] overall_q, overall_d;
    logic [RW-1:0] hit_bin_q, hit_bin_d;
    logic          hit_valid_q, hit_valid_d;
    logic [HW-1:0] hcnt_q, hcnt_d;

    generate
        for (genvar k = 0; k < NUM_BINS; k++) begin : g_unpack
            assign pw_w[k] = bus.power[k*POWER_W +: POWER_W];
            // A zero floor admits everything; skip the always-true compare.
            if (MIN_POWER == 0) begin : g_no_floor
                assign floor_ok_w[k] = 1'b1;
            end else begin : g_floor
                assign floor_ok_w[k] = (pw_w[k] >= MIN_P);
            end
        end
    endgenerate

    // Lowest-index bin that dominates every other bin by 2^SHIFT and clears the floor.
    always_comb begin
        cls_w   = RW'(SILENCE);
        found_w = 1'b0;
        dom_w   = 1'b0;
        for (int i = 0; i < NUM_BINS; i++) begin
            dom_w = 1'b1;
            for (int j = 0; j < NUM_BINS; j++) begin
                if (j != i && !((pw_w[i] >> SHIFT) > pw_w[j]))
                    dom_w = 1'b0;
            end
            if (!found_w && dom_w && floor_ok_w[i]) begin
                cls_w   = RW'(i + 1);
                found_w = 1'b1;
            end
        end
    end

    assign result_d = bus.advance ? cls_w : result_q;

    vote_window #(
        .NUM_BINS (NUM_BINS),
        .WINDOW   (WINDOW)
    ) u_win (
        .clk           (clk),
        .reset         (reset),
        .shift_en      (adv1_q),
        .din           (result_q),
        .counts        (counts_w),
        .silence_votes (silence_w)
    );

    // Lowest-index bin holding at least THRESH votes in the window.
    always_comb begin
        nov_w = RW'(SILENCE);
        for (int i = NUM_BINS - 1; i >= 0; i--) begin
            if (counts_w[i] >= CW'(THRESH))
                nov_w = RW'(i + 1);
        end
    end

    // Onset FSM; only stage-2 edges (one per window update) advance it.
    always_comb begin
        state_d     = state_q;
        overall_d   = overall_q;
        hit_bin_d   = hit_bin_q;
        hit_valid_d = 1'b0;
        hcnt_d      = hcnt_q;
        if (adv2_q) begin
            overall_d = nov_w;
            case (state_q)
                ST_QUIET: begin
                    if (nov_w != RW'(SILENCE)) begin
                        hit_valid_d = 1'b1;
                        hit_bin_d   = nov_w;
                        state_d     = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (nov_w == RW'(SILENCE)) begin
                        state_d = ST_HOLDOFF;
                        hcnt_d  = HW'(HOLDOFF);
                    end else if (nov_w != hit_bin_q) begin
                        hit_valid_d = 1'b1;
                        hit_bin_d   = nov_w;
                    end
                end
                ST_HOLDOFF: begin
                    if (HOLDOFF == 0 || hcnt_q <= HW'(1)) begin
                        state_d = ST_QUIET;
                        hcnt_d  = '0;
                    end else begin
                        hcnt_d  = hcnt_q - HW'(1);
                    end
                end
                default: state_d = ST_QUIET;
            endcase
        end
    end

    // Pipeline flags, classification register and FSM state; reset drops in-flight advances.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q    <= RW'(SILENCE);
            adv1_q      <= 1'b0;
            adv2_q      <= 1'b0;
            state_q     <= ST_QUIET;
            overall_q   <= RW'(SILENCE);
            hit_bin_q   <= RW'(SILENCE);
            hit_valid_q <= 1'b0;
            hcnt_q      <= '0;
        end else begin
            result_q    <= result_d;
            adv1_q      <= bus.advance;
            adv2_q      <= adv1_q;
            state_q     <= state_d;
            overall_q   <= overall_d;
            hit_bin_q   <= hit_bin_d;
            hit_valid_q <= hit_valid_d;
            hcnt_q      <= hcnt_d;
        end
    end

    assign bus.result         = result_q;
    assign bus.overall_result = overall_q;
    assign bus.hit_valid      = hit_valid_q;
    assign bus.hit_bin        = hit_bin_q;
    assign bus.silence_votes  = silence_w;

endmodule
`default_nettype wire

// File: tb/tb_hit_detector_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hit_detector_n
//  Description : Directed self-checking bench for hit_detector_n
//                (4 bins x 64 bits, SHIFT 3, WINDOW 16, THRESH 8, HOLDOFF 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hit_detector_n;
    import hit_det_pkg::*;

    localparam int NB = 4;
    localparam int PW = 64;
    localparam int WN = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic mon_en = 1'b0;
    logic prev_hv = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   hit_cnt = 0;

    always #5 clk = ~clk;

    hit_detector_n_if #(.NUM_BINS(NB), .POWER_W(PW), .WINDOW(WN)) bus ();

    hit_detector_n #(
        .NUM_BINS (NB), .POWER_W (PW), .SHIFT (3), .MIN_POWER (0),
        .WINDOW (WN), .THRESH (8), .HOLDOFF (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // First argument is bin code 1 (bits [63:0]).
    function automatic logic [NB*PW-1:0] pw4(input logic [63:0] b1, b2, b3, b4);
        return {b4, b3, b2, b1};
    endfunction

    function automatic logic [NB*PW-1:0] code_pw(input int code);
        case (code)
            1:       return pw4(1000, 100, 100, 100);
            2:       return pw4(100, 1000, 100, 100);
            3:       return pw4(100, 100, 1000, 100);
            4:       return pw4(100, 100, 100, 1000);
            default: return '0;
        endcase
    endfunction

    // Vote bookkeeping must always account for exactly WINDOW entries; also counts hit pulses.
    always @(negedge clk) begin : mon
        int sum;
        if (mon_en) begin
            sum = int'(bus.silence_votes);
            for (int k = 0; k < NB; k++) begin
                sum += int'(dut.u_win.counts[k]);
                n_cmp++;
                if (dut.u_win.counts[k] > 5'd16) begin
                    n_fail++;
                    $display("FAIL count_range bin%0d: count=%0d limit=16", k + 1, dut.u_win.counts[k]);
                end
            end
            n_cmp++;
            if (sum !== WN) begin
                n_fail++;
                $display("FAIL vote_sum: sum=%0d want %0d", sum, WN);
            end
            if (bus.hit_valid === 1'b1) begin
                hit_cnt++;
                n_cmp++;
                if (prev_hv === 1'b1) begin
                    n_fail++;
                    $display("FAIL hit_pulse_width: hit_valid high 2 cycles, want 1");
                end
            end
            prev_hv = bus.hit_valid;
        end
    end

    task automatic adv(input logic [NB*PW-1:0] p);
        @(negedge clk);
        bus.advance = 1'b1;
        bus.power   = p;
        @(negedge clk);
        bus.advance = 1'b0;
    endtask

    // Advance and wait until its stage-2 effects are visible.
    task automatic adv_wait(input logic [NB*PW-1:0] p);
        adv(p);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b0;
        bus.advance = 1'b0;
        bus.power   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int h0;
        bus.advance = 1'b0;
        bus.power   = '0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        n_cmp++; if (bus.result !== 3'd0) begin n_fail++; $display("FAIL rst_result: got %0d want 0", bus.result); end
        n_cmp++; if (bus.overall_result !== 3'd0) begin n_fail++; $display("FAIL rst_overall: got %0d want 0", bus.overall_result); end
        n_cmp++; if (bus.hit_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hit_valid: got %0b want 0", bus.hit_valid); end
        n_cmp++; if (bus.hit_bin !== 3'd0) begin n_fail++; $display("FAIL rst_hit_bin: got %0d want 0", bus.hit_bin); end
        n_cmp++; if (bus.silence_votes !== 5'd16) begin n_fail++; $display("FAIL rst_silence: got %0d want 16", bus.silence_votes); end
        reset = 1'b1;
        h0 = hit_cnt;
        repeat (100) @(negedge clk);
        #1;
        n_cmp++; if (hit_cnt !== h0) begin n_fail++; $display("FAIL idle_hits: got %0d want 0", hit_cnt - h0); end
        n_cmp++; if (bus.result !== 3'd0) begin n_fail++; $display("FAIL idle_result: got %0d want 0", bus.result); end
        n_cmp++; if (bus.overall_result !== 3'd0) begin n_fail++; $display("FAIL idle_overall: got %0d want 0", bus.overall_result); end
        n_cmp++; if (bus.silence_votes !== 5'd16) begin n_fail++; $display("FAIL idle_silence: got %0d want 16", bus.silence_votes); end
    endtask

    task automatic test_dominance();
        logic [NB*PW-1:0] dp [7];
        logic [2:0]       de [7];
        do_reset();
        dp[0] = pw4(1000, 100, 100, 100); de[0] = 3'd1;
        dp[1] = pw4(1000, 200, 100, 100); de[1] = 3'd0;  // 125 not > 200
        dp[2] = pw4(800, 100, 100, 100);  de[2] = 3'd0;  // 100 not > 100
        dp[3] = pw4(0, 0, 0, 8);          de[3] = 3'd4;  // 1 > 0
        dp[4] = pw4(1000, 1000, 0, 0);    de[4] = 3'd0;
        dp[5] = pw4(0, 0, 0, 0);          de[5] = 3'd0;
        dp[6] = pw4(1000, 124, 0, 0);     de[6] = 3'd1;  // 125 > 124
        for (int i = 0; i < 7; i++) begin
            adv(dp[i]);
            n_cmp++;
            if (bus.result !== de[i]) begin
                n_fail++;
                $display("FAIL dominance[%0d]: result=%0d want %0d", i, bus.result, de[i]);
            end
        end
        adv(code_pw(3));
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.result !== 3'd3) begin n_fail++; $display("FAIL result_hold: got %0d want 3", bus.result); end
    endtask

    task automatic test_majority();
        int h0;
        do_reset();
        h0 = hit_cnt;
        repeat (7) adv_wait(code_pw(3));
        n_cmp++; if (hit_cnt !== h0) begin n_fail++; $display("FAIL maj_7_hits: got %0d want 0", hit_cnt - h0); end
        n_cmp++; if (bus.overall_result !== 3'd0) begin n_fail++; $display("FAIL maj_7_overall: got %0d want 0", bus.overall_result); end
        n_cmp++; if (bus.silence_votes !== 5'd9) begin n_fail++; $display("FAIL maj_7_silence: got %0d want 9", bus.silence_votes); end
        adv(code_pw(3));
        n_cmp++; if (bus.result !== 3'd3) begin n_fail++; $display("FAIL maj_k_result: got %0d want 3", bus.result); end
        n_cmp++; if (bus.silence_votes !== 5'd9) begin n_fail++; $display("FAIL maj_k_silence: got %0d want 9", bus.silence_votes); end
        @(negedge clk);
        n_cmp++; if (bus.silence_votes !== 5'd8) begin n_fail++; $display("FAIL maj_k1_silence: got %0d want 8", bus.silence_votes); end
        n_cmp++; if (bus.overall_result !== 3'd0) begin n_fail++; $display("FAIL maj_k1_overall: got %0d want 0", bus.overall_result); end
        n_cmp++; if (bus.hit_valid !== 1'b0) begin n_fail++; $display("FAIL maj_k1_hv: got %0b want 0", bus.hit_valid); end
        @(negedge clk);
        n_cmp++; if (bus.overall_result !== 3'd3) begin n_fail++; $display("FAIL maj_k2_overall: got %0d want 3", bus.overall_result); end
        n_cmp++; if (bus.hit_valid !== 1'b1) begin n_fail++; $display("FAIL maj_k2_hv: got %0b want 1", bus.hit_valid); end
        n_cmp++; if (bus.hit_bin !== 3'd3) begin n_fail++; $display("FAIL maj_k2_bin: got %0d want 3", bus.hit_bin); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus.hit_valid !== 1'b0) begin n_fail++; $display("FAIL maj_k3_hv: got %0b want 0", bus.hit_valid); end
        n_cmp++; if (hit_cnt !== h0 + 1) begin n_fail++; $display("FAIL maj_hits: got %0d want 1", hit_cnt - h0); end
    endtask

    task automatic test_holdoff();
        int seq [16] = '{3, 0, 3, 3, 3, 3, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0};
        int h0;
        do_reset();
        h0 = hit_cnt;
        for (int i = 0; i < 16; i++) adv_wait(code_pw(seq[i]));
        n_cmp++; if (hit_cnt !== h0 + 1) begin n_fail++; $display("FAIL ho_first_hit: got %0d want 1", hit_cnt - h0); end
        n_cmp++; if (bus.overall_result !== 3'd3) begin n_fail++; $display("FAIL ho_first_overall: got %0d want 3", bus.overall_result); end
        adv_wait(code_pw(0));
        n_cmp++; if (bus.overall_result !== 3'd0) begin n_fail++; $display("FAIL ho_end_overall: got %0d want 0", bus.overall_result); end
        h0 = hit_cnt;
        for (int i = 0; i < 4; i++) begin
            adv_wait(code_pw(3));
            n_cmp++; if (bus.overall_result !== 3'd3) begin n_fail++; $display("FAIL ho_overall[%0d]: got %0d want 3", i, bus.overall_result); end
            n_cmp++; if (hit_cnt !== h0) begin n_fail++; $display("FAIL ho_suppress[%0d]: hits=%0d want 0", i, hit_cnt - h0); end
        end
        adv_wait(code_pw(3));
        n_cmp++; if (hit_cnt !== h0 + 1) begin n_fail++; $display("FAIL ho_refire: hits=%0d want 1", hit_cnt - h0); end
        n_cmp++; if (bus.hit_bin !== 3'd3) begin n_fail++; $display("FAIL ho_refire_bin: got %0d want 3", bus.hit_bin); end
    endtask

    task automatic test_bin_change();
        int h0;
        do_reset();
        h0 = hit_cnt;
        repeat (8) adv_wait(code_pw(1));
        n_cmp++; if (hit_cnt !== h0 + 1) begin n_fail++; $display("FAIL bc_hit1: hits=%0d want 1", hit_cnt - h0); end
        n_cmp++; if (bus.hit_bin !== 3'd1) begin n_fail++; $display("FAIL bc_bin1: got %0d want 1", bus.hit_bin); end
        repeat (8) adv_wait(code_pw(2));
        n_cmp++; if (bus.overall_result !== 3'd1) begin n_fail++; $display("FAIL bc_tie_overall: got %0d want 1", bus.overall_result); end
        n_cmp++; if (bus.silence_votes !== 5'd0) begin n_fail++; $display("FAIL bc_silence: got %0d want 0", bus.silence_votes); end
        n_cmp++; if (hit_cnt !== h0 + 1) begin n_fail++; $display("FAIL bc_tie_hits: hits=%0d want 1", hit_cnt - h0); end
        adv_wait(code_pw(2));
        n_cmp++; if (hit_cnt !== h0 + 2) begin n_fail++; $display("FAIL bc_hit2: hits=%0d want 2", hit_cnt - h0); end
        n_cmp++; if (bus.hit_bin !== 3'd2) begin n_fail++; $display("FAIL bc_bin2: got %0d want 2", bus.hit_bin); end
        n_cmp++; if (bus.overall_result !== 3'd2) begin n_fail++; $display("FAIL bc_overall2: got %0d want 2", bus.overall_result); end
    endtask

    task automatic test_back_to_back();
        int h0;
        do_reset();
        h0 = hit_cnt;
        @(negedge clk);
        bus.advance = 1'b1;
        bus.power   = code_pw(2);
        repeat (8) @(negedge clk);
        bus.advance = 1'b0;
        n_cmp++; if (bus.result !== 3'd2) begin n_fail++; $display("FAIL b2b_result: got %0d want 2", bus.result); end
        n_cmp++; if (bus.overall_result !== 3'd0) begin n_fail++; $display("FAIL b2b_k_overall: got %0d want 0", bus.overall_result); end
        @(negedge clk);
        n_cmp++; if (bus.hit_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_k1_hv: got %0b want 0", bus.hit_valid); end
        @(negedge clk);
        n_cmp++; if (bus.hit_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_k2_hv: got %0b want 1", bus.hit_valid); end
        n_cmp++; if (bus.overall_result !== 3'd2) begin n_fail++; $display("FAIL b2b_k2_overall: got %0d want 2", bus.overall_result); end
        n_cmp++; if (bus.silence_votes !== 5'd8) begin n_fail++; $display("FAIL b2b_silence: got %0d want 8", bus.silence_votes); end
        @(negedge clk);
        #1;
        n_cmp++; if (hit_cnt !== h0 + 1) begin n_fail++; $display("FAIL b2b_hits: got %0d want 1", hit_cnt - h0); end
    endtask

    task automatic test_reset_mid();
        int h0;
        do_reset();
        repeat (7) adv_wait(code_pw(3));
        h0 = hit_cnt;
        adv(code_pw(3));
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.result !== 3'd0) begin n_fail++; $display("FAIL mid_result: got %0d want 0", bus.result); end
        n_cmp++; if (bus.overall_result !== 3'd0) begin n_fail++; $display("FAIL mid_overall: got %0d want 0", bus.overall_result); end
        n_cmp++; if (bus.hit_valid !== 1'b0) begin n_fail++; $display("FAIL mid_hv: got %0b want 0", bus.hit_valid); end
        n_cmp++; if (bus.hit_bin !== 3'd0) begin n_fail++; $display("FAIL mid_bin: got %0d want 0", bus.hit_bin); end
        n_cmp++; if (bus.silence_votes !== 5'd16) begin n_fail++; $display("FAIL mid_silence: got %0d want 16", bus.silence_votes); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        n_cmp++; if (hit_cnt !== h0) begin n_fail++; $display("FAIL mid_hits: got %0d want 0", hit_cnt - h0); end
        n_cmp++; if (bus.overall_result !== 3'd0) begin n_fail++; $display("FAIL mid_post_overall: got %0d want 0", bus.overall_result); end
    endtask

    initial begin
        test_reset();
        test_dominance();
        test_majority();
        test_holdoff();
        test_bin_change();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/hit_detector_n.md
Name: hit_detector_n

Overview:
- Parametrised successor to the 4-bin detector. It classifies NUM_BINS power inputs into "silence" or one dominant bin on each advance strobe.
- A sliding window of past classifications drives a majority vote. Onset events are emitted through a hold-off state machine.
- Sits between the per-bin power/Goertzel stage and the software-visible hit register.

Parameters:
- NUM_BINS, 4: number of power channels; bin codes are 1..NUM_BINS, 0 = silence.
- POWER_W, 64: width of each unsigned power input.
- SHIFT, 3: dominance ratio 2^SHIFT; bin i dominates if (power_i >> SHIFT) > power_j for every j != i.
- MIN_POWER, 0: bin i is also required to satisfy power_i >= MIN_POWER (noise floor).
- WINDOW, 16: number of classifications in the voting window (>= 2).
- THRESH, 8: votes needed within WINDOW for a bin to win (1..WINDOW).
- HOLDOFF, 4: number of window updates suppressed after a hit ends.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- advance  in  1  one-cycle strobe; new power sample set is valid
- power  in  NUM_BINS*POWER_W  flattened powers; bin k occupies bits [k*POWER_W +: POWER_W], k = 0..NUM_BINS-1 maps to code k+1
- result  out  RW  instantaneous classification, RW = $clog2(NUM_BINS+1)
- overall_result  out  RW  windowed majority classification
- hit_valid  out  1  one-cycle pulse on hit onset
- hit_bin  out  RW  bin code of the last hit; held until the next hit
- silence_votes  out  CW  silence count in the window, CW = $clog2(WINDOW+1)

Behaviour:
- Reset (reset low, asynchronous):
  - result, overall_result, hit_bin, hit_valid = 0.
  - Window is filled with silence, so silence_votes = WINDOW and all bin counts = 0.
  - FSM goes to QUIET; hold-off counter = 0; advance pipeline flags cleared.
- Stage 0, at an edge with advance = 1:
  - result <= classify(power); adv_d <= 1.
  - When advance = 0, result holds its value and adv_d <= 0.
  - classify: lowest-index bin meeting both the dominance and MIN_POWER rules wins; if none qualifies, result is 0.
  - Comparisons are unsigned at full POWER_W width; the shift is logical.
- Stage 1, at an edge with adv_d = 1:
  - Window shifts: slot 0 <= result, slot i <= slot i-1; the oldest entry is dropped.
  - If the new entry differs from the dropped one, the new code's count increments and the dropped code's count decrements in the same edge.
  - If they are equal, no count changes.
  - Counts never exceed WINDOW and never underflow; the bench asserts this.
  - Sets adv_d2 <= 1.
- Stage 2, at an edge with adv_d2 = 1:
  - overall_result <= the lowest-index bin with count >= THRESH, else 0.
  - The FSM evaluates the same next overall value (nov) in this edge.
- Latency: advance at edge k gives result at k, counts at k+1, and overall_result/hit_valid at k+2.
- Back-to-back advance every cycle is fully supported, with no stalls.
- FSM transitions (evaluated only on stage-2 edges):
  - QUIET: nov != 0 -> pulse hit_valid, hit_bin <= nov, go to HELD.
  - HELD, nov == 0: go to HOLDOFF; counter <= HOLDOFF.
  - HELD, nov != hit_bin and nonzero: pulse hit_valid, hit_bin <= nov, stay in HELD.
  - HELD, otherwise: stay in HELD.
  - HOLDOFF: counter decrements on each stage-2 edge and no event is emitted. At counter == 1 (or HOLDOFF == 0), go to QUIET on that edge.
  - Any pending hit fires at the next stage-2 edge evaluated in QUIET.
- hit_valid is high for exactly one cycle, the cycle after the stage-2 edge.
- Reset asserted mid-pipeline discards all in-flight advances; no hit_valid may appear after reset release without fresh advances.

Decomposition:
- Package hit_det_pkg holds:
  - state enum {QUIET, HELD, HOLDOFF};
  - helper functions for RW/CW widths;
  - the SILENCE = 0 constant.
- Sub-module vote_window: shift register plus per-code counters (ports clk, reset, shift_en, din, counts, silence_votes), instantiated once.
- Classification and the FSM stay in hit_detector_n.

Test Plan:
- Reset then idle: after release, result = 0, overall_result = 0, silence_votes = 16, hit_valid never asserts over 100 cycles.
- Dominance: power = {1000,100,100,100} with SHIFT = 3 -> result = 1. Power = {1000,200,100,100} -> result = 0, since 1000>>3 = 125 is not > 200.
- Majority and latency: 8 consecutive advances with bin 3 dominant:
  - the 8th advance at edge k gives overall_result = 3 and a single hit_valid (hit_bin = 3) after edge k+2;
  - the 7th advance produces no hit.
- Hold-off: after that hit, feed silence until overall_result = 0, then bin 3 again. No hit_valid may occur within 4 window updates; a hit fires on the first stage-2 edge in QUIET.
- Bin change while HELD: window majority moves from bin 1 to bin 2 with no silence gap -> second hit_valid with hit_bin = 2. Counts always sum to 16.
- Async reset mid-stream: assert reset 2 cycles after an advance that would complete a majority -> no hit_valid, all outputs 0 immediately, silence_votes = 16.
